// File: rtl/zbb_cnt_seq_if.sv
// Request/response bundle between the execute stage and the Zbb bit-count sequencer.
// The core drives the request side and the sequencer drives the response side.
interface zbb_cnt_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src;
  logic [4:0]  req_rd;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        busy;

  modport master (
    output req_valid, req_op, req_src, req_rd, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, busy
  );

  modport slave (
    input  req_valid, req_op, req_src, req_rd, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd, busy
  );
endinterface

// File: rtl/zbb_cnt_seq.sv
// Iterative clz/ctz/cpop unit: scans STEP_BITS bits per cycle with a fixed latency
// of 32/STEP_BITS cycles, holding one operation at a time.
module zbb_cnt_seq #(
  parameter int STEP_BITS = 4
) (
  input logic          clk,
  input logic          rst,
  zbb_cnt_seq_if.slave bus
);

  localparam int N = 32 / STEP_BITS;
  localparam logic [5:0] LAST_STEP = 6'(N - 1);
  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  generate
    if (!(STEP_BITS == 1 || STEP_BITS == 2 || STEP_BITS == 4 || STEP_BITS == 8)) begin : gBadStep
      $error("zbb_cnt_seq: STEP_BITS must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t      state, stateNext;
  logic [31:0] sr;
  logic [5:0]  acc, accNext;
  logic        found, foundNext;
  logic [5:0]  step;
  logic [1:0]  opReg;
  logic [4:0]  rdReg;
  logic [31:0] rspData;
  logic        accept, rspFire, lastStep;

  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always_comb begin
    accept   = bus.req_valid && bus.req_ready;
    rspFire  = bus.rsp_valid && bus.rsp_ready;
    lastStep = (step == LAST_STEP);
  end

  // clz is turned into ctz by bit-reversing at accept, so every op scans LSB first.
  always_comb begin
    accNext   = acc;
    foundNext = found;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (opReg == OP_CPOP) begin
        accNext = accNext + {5'b0, sr[i]};
      end else if (opReg != OP_RSVD && !foundNext) begin
        if (sr[i]) foundNext = 1'b1;
        else       accNext   = accNext + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = RUN;
      RUN: begin
        if (bus.flush)    stateNext = IDLE;
        else if (lastStep) stateNext = RESP;
      end
      RESP: if (rspFire || bus.flush) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && !bus.flush && !rst;
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state != IDLE);
    bus.rsp_data  = rspData;
    bus.rsp_rd    = rdReg;
  end

  // Datapath only advances in RUN; a flush just abandons it and the next accept reinitialises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      acc     <= '0;
      found   <= 1'b0;
      step    <= '0;
      opReg   <= '0;
      rdReg   <= '0;
      rspData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opReg <= bus.req_op;
            rdReg <= bus.req_rd;
            sr    <= (bus.req_op == OP_CLZ) ? reverse32(bus.req_src) : bus.req_src;
            acc   <= '0;
            found <= 1'b0;
            step  <= '0;
          end
        end
        RUN: begin
          if (!bus.flush) begin
            sr    <= sr >> STEP_BITS;
            acc   <= accNext;
            found <= foundNext;
            step  <= step + 6'd1;
            if (lastStep) rspData <= {26'b0, accNext};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zbb_cnt_seq.sv
// Scoreboard bench for zbb_cnt_seq: directed vectors on a STEP_BITS=4 instance plus a
// random sweep on STEP_BITS=1/2/8 instances checked against a reference count model.
module tb_zbb_cnt_seq;

  localparam int CLK_HALF = 5;
  localparam logic [1:0] CLZ = 2'b00, CTZ = 2'b01, CPOP = 2'b10, RSVD = 2'b11;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          acceptCycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t mainQ[$];
  exp_t sweepQ[$];

  always #CLK_HALF clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  zbb_cnt_seq_if mainBus ();

  zbb_cnt_seq #(.STEP_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mainBus)
  );

  logic        swReqValid = 1'b0;
  logic [1:0]  swReqOp    = '0;
  logic [31:0] swReqSrc   = '0;
  logic [4:0]  swReqRd    = '0;
  logic [2:0]  swReqReady;
  logic [2:0]  swRspValid;
  logic [2:0][31:0] swRspData;
  logic [2:0][4:0]  swRspRd;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gSweep
      localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
      zbb_cnt_seq_if bus ();
      assign bus.req_valid = swReqValid;
      assign bus.req_op    = swReqOp;
      assign bus.req_src   = swReqSrc;
      assign bus.req_rd    = swReqRd;
      assign bus.flush     = 1'b0;
      assign bus.rsp_ready = 1'b1;
      assign swReqReady[g] = bus.req_ready;
      assign swRspValid[g] = bus.rsp_valid;
      assign swRspData[g]  = bus.rsp_data;
      assign swRspRd[g]    = bus.rsp_rd;
      zbb_cnt_seq #(.STEP_BITS(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  function automatic int sweepLatency(input int k);
    return (k == 0) ? 32 : (k == 1) ? 16 : 4;
  endfunction

  // Reference counts computed directly from the operand, MSB-first for clz.
  function automatic logic [31:0] refCount(input logic [1:0] op, input logic [31:0] s);
    int n = 0;
    int i;
    case (op)
      CLZ: begin
        i = 31;
        while (i >= 0 && !s[i]) begin n++; i--; end
      end
      CTZ: begin
        i = 0;
        while (i < 32 && !s[i]) begin n++; i++; end
      end
      CPOP: n = $countones(s);
      default: n = 0;
    endcase
    return 32'(n);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Main monitor: pops an expectation on every response handshake.
  logic prevValid = 1'b0;
  int   riseCycle = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (mainBus.rsp_valid && !prevValid) riseCycle = cycle;
    prevValid = mainBus.rsp_valid;
    if (mainBus.rsp_valid && mainBus.rsp_ready) begin
      checkOutput("rspExpected", 32'(mainQ.size() > 0), 32'd1);
      if (mainQ.size() > 0) begin
        e = mainQ.pop_front();
        checkOutput("rspData", mainBus.rsp_data, e.data);
        checkOutput("rspRd", 32'(mainBus.rsp_rd), 32'(e.rd));
        checkOutput("rspLatency", 32'(riseCycle - e.acceptCycle), 32'd8);
      end
    end
  end

  // Sweep monitor: each instance answers the head expectation once, then it is popped.
  logic [2:0] swDone = '0;
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (swRspValid[k]) begin
        checkOutput("swRspExpected", 32'(sweepQ.size() > 0 && !swDone[k]), 32'd1);
        if (sweepQ.size() > 0 && !swDone[k]) begin
          checkOutput($sformatf("swData%0d", k), swRspData[k], sweepQ[0].data);
          checkOutput($sformatf("swRd%0d", k), 32'(swRspRd[k]), 32'(sweepQ[0].rd));
          checkOutput($sformatf("swLatency%0d", k), 32'(cycle - sweepQ[0].acceptCycle),
                      32'(sweepLatency(k)));
          swDone[k] = 1'b1;
        end
      end
    end
    if (swDone == 3'b111) begin
      void'(sweepQ.pop_front());
      swDone = '0;
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] src, input logic [4:0] rd,
                               input logic [31:0] expData, input bit doExpect);
    int budget = 100;
    @(negedge clk);
    while (!mainBus.req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("reqReadyWait", 32'(mainBus.req_ready), 32'd1);
    mainBus.req_valid = 1'b1;
    mainBus.req_op    = op;
    mainBus.req_src   = src;
    mainBus.req_rd    = rd;
    if (doExpect) mainQ.push_back('{expData, rd, cycle + 1});
    @(negedge clk);
    mainBus.req_valid = 1'b0;
    mainBus.req_op    = op + 2'd1;
    mainBus.req_src   = ~src;
    mainBus.req_rd    = ~rd;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((mainQ.size() > 0 || mainBus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainQueue", 32'(mainQ.size()), 32'd0);
  endtask

  task automatic waitRspValid(input int budget);
    int n = 0;
    while (!mainBus.rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rspValidWait", 32'(mainBus.rsp_valid), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "RspValid"}, 32'(mainBus.rsp_valid), 32'd0);
    checkOutput({tag, "RspData"}, mainBus.rsp_data, 32'd0);
    checkOutput({tag, "RspRd"}, 32'(mainBus.rsp_rd), 32'd0);
    checkOutput({tag, "Busy"}, 32'(mainBus.busy), 32'd0);
  endtask

  initial begin
    #(2 * CLK_HALF * 80000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] src;
    logic [4:0]  rd;
    int          n;

    mainBus.req_valid = 1'b0;
    mainBus.req_op    = '0;
    mainBus.req_src   = '0;
    mainBus.req_rd    = '0;
    mainBus.flush     = 1'b0;
    mainBus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("resetReqReady", 32'(mainBus.req_ready), 32'd0);
    checkResetState("reset");
    rst = 1'b0;
    #1;
    checkOutput("postResetReqReady", 32'(mainBus.req_ready), 32'd1);

    // Main function and boundaries with the consumer always ready.
    applyStimulus(CLZ,  32'h0001_0000, 5'd1,  32'd15, 1'b1);
    applyStimulus(CTZ,  32'h0001_0000, 5'd2,  32'd16, 1'b1);
    applyStimulus(CPOP, 32'hF0F0_0001, 5'd3,  32'd9,  1'b1);
    applyStimulus(CLZ,  32'h8000_0000, 5'd4,  32'd0,  1'b1);
    applyStimulus(CLZ,  32'h0000_0000, 5'd5,  32'd32, 1'b1);
    applyStimulus(CTZ,  32'h0000_0000, 5'd6,  32'd32, 1'b1);
    applyStimulus(CPOP, 32'hFFFF_FFFF, 5'd7,  32'd32, 1'b1);
    applyStimulus(CPOP, 32'h0000_0000, 5'd8,  32'd0,  1'b1);
    applyStimulus(CTZ,  32'h8000_0000, 5'd30, 32'd31, 1'b1);
    applyStimulus(RSVD, 32'hFFFF_FFFF, 5'd31, 32'd0,  1'b1);
    waitDrain(40);

    // Backpressure in RESP, then a back-to-back request right after the handshake.
    mainBus.rsp_ready = 1'b0;
    applyStimulus(CPOP, 32'h1234_5678, 5'd7, 32'd13, 1'b1);
    waitRspValid(20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpRspValid", 32'(mainBus.rsp_valid), 32'd1);
      checkOutput("bpRspData", mainBus.rsp_data, 32'd13);
      checkOutput("bpRspRd", 32'(mainBus.rsp_rd), 32'd7);
      checkOutput("bpReqReady", 32'(mainBus.req_ready), 32'd0);
      checkOutput("bpBusy", 32'(mainBus.busy), 32'd1);
      @(negedge clk);
    end
    mainBus.rsp_ready = 1'b1;
    mainBus.req_valid = 1'b1;
    mainBus.req_op    = CTZ;
    mainBus.req_src   = 32'h0000_0100;
    mainBus.req_rd    = 5'd9;
    @(negedge clk);
    checkOutput("b2bReqReady", 32'(mainBus.req_ready), 32'd1);
    checkOutput("b2bIdle", 32'(mainBus.busy), 32'd0);
    mainQ.push_back('{32'd8, 5'd9, cycle + 1});
    @(negedge clk);
    mainBus.req_valid = 1'b0;
    checkOutput("b2bAccepted", 32'(mainBus.busy), 32'd1);
    waitDrain(40);

    // Flush in the third RUN cycle: the operation must vanish.
    applyStimulus(CLZ, 32'h0000_00FF, 5'd10, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mainBus.flush = 1'b1;
    @(negedge clk);
    mainBus.flush = 1'b0;
    checkOutput("flushBusy", 32'(mainBus.busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("flushNoRsp", 32'(mainBus.rsp_valid), 32'd0);
      @(negedge clk);
    end

    // Flush in IDLE blocks acceptance of a simultaneous request.
    mainBus.flush     = 1'b1;
    mainBus.req_valid = 1'b1;
    mainBus.req_op    = CPOP;
    mainBus.req_src   = 32'hFFFF_FFFF;
    mainBus.req_rd    = 5'd11;
    #1;
    checkOutput("flushIdleReqReady", 32'(mainBus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("flushIdleNotAccepted", 32'(mainBus.busy), 32'd0);
    mainBus.flush     = 1'b0;
    mainBus.req_valid = 1'b0;
    applyStimulus(CLZ, 32'h0000_FFFF, 5'd12, 32'd16, 1'b1);
    waitDrain(40);

    // Reset mid-RUN.
    applyStimulus(CTZ, 32'h0000_0000, 5'd5, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstRunReqReady", 32'(mainBus.req_ready), 32'd0);
    checkResetState("rstRun");
    rst = 1'b0;
    #1;
    checkOutput("rstRunReqReadyAfter", 32'(mainBus.req_ready), 32'd1);

    // Reset mid-RESP with the response still pending.
    mainBus.rsp_ready = 1'b0;
    applyStimulus(CPOP, 32'h0000_00FF, 5'd6, 32'd0, 1'b0);
    waitRspValid(20);
    checkOutput("rstRespPending", mainBus.rsp_data, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("rstResp");
    rst = 1'b0;
    mainBus.rsp_ready = 1'b1;
    #1;
    checkOutput("rstRespReqReadyAfter", 32'(mainBus.req_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Random sweep over STEP_BITS 1, 2, 8 against the reference model.
    for (int t = 0; t < 1000; t++) begin
      op  = 2'($urandom_range(0, 3));
      src = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) src = ~src;
      if (t == 0) src = 32'h0000_0000;
      if (t == 1) src = 32'hFFFF_FFFF;
      rd  = 5'($urandom_range(0, 31));
      @(negedge clk);
      checkOutput("swReqReady", 32'(swReqReady), 32'd7);
      swReqValid = 1'b1;
      swReqOp    = op;
      swReqSrc   = src;
      swReqRd    = rd;
      sweepQ.push_back('{refCount(op, src), rd, cycle + 1});
      @(negedge clk);
      swReqValid = 1'b0;
      swReqSrc   = $urandom;
      swReqOp    = 2'($urandom_range(0, 3));
      n = 0;
      while (sweepQ.size() > 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("swDrain", 32'(sweepQ.size()), 32'd0);
      if (sweepQ.size() > 0) begin
        sweepQ.delete();
        swDone = '0;
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
